// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: three-state FETCH/WAIT/VALID sequencer driving a synchronous
// instruction RAM, holding the program counter and instruction register.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_WORD = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PC_enable,
   input  logic        branch_en,
   input  logic [7:0]  branch_disp,
   input  logic        jump_en,
   input  logic [15:0] jump_addr,
   input  logic [15:0] mem_rdata,
   output logic [15:0] pc,
   output logic [15:0] instruction,
   output logic        instr_valid,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {StFetch, StWait, StValid} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] branch_offset;
   logic        retire;

   // PC_enable only counts once the instruction is valid.
   assign retire        = (state_q == StValid) && PC_enable;
   assign branch_offset = {{8{branch_disp[7]}}, branch_disp};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: state_d = StWait;
         StWait:  state_d = StValid;
         StValid: if (PC_enable) state_d = StFetch;
         default: state_d = StFetch;
      endcase
   end

   always_comb begin
      instr_valid = (state_q == StValid);
      fetch_busy  = !instr_valid;
   end

   // Jump wins over branch; arithmetic wraps modulo 2^16 by width.
   always_comb begin
      pc_d = pc_q;
      if (retire) begin
         if (jump_en) begin
            pc_d = jump_addr;
         end else if (branch_en) begin
            pc_d = pc_q + branch_offset;
         end else begin
            pc_d = pc_q + 16'd1;
         end
      end
   end

   // RAM data for pc is valid during WAIT; capture it at the end of that cycle.
   always_comb begin
      ir_d = ir_q;
      if (state_q == StWait) begin
         ir_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
         ir_q <= NOP_WORD;
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
      end
   end

   assign pc          = pc_q;
   assign instruction = ir_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a synchronous RAM model and
// table-driven PC-update vectors plus directed multi-cycle sequences.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        PC_enable;
   logic        branch_en;
   logic [7:0]  branch_disp;
   logic        jump_en;
   logic [15:0] jump_addr;
   logic [15:0] mem_rdata;
   logic [15:0] pc;
   logic [15:0] instruction;
   logic        instr_valid;
   logic        fetch_busy;

   int n_cmp;
   int n_err;

   instr_fetch_unit #(
      .RESET_PC (16'h0000),
      .NOP_WORD (16'h0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .PC_enable   (PC_enable),
      .branch_en   (branch_en),
      .branch_disp (branch_disp),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .mem_rdata   (mem_rdata),
      .pc          (pc),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .fetch_busy  (fetch_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: address 0 holds 16'h0123, others a byte-swap pattern.
   function automatic logic [15:0] instr_at(input logic [15:0] a);
      if (a == 16'h0000) return 16'h0123;
      return {a[7:0], a[15:8]} ^ 16'h5A00;
   endfunction

   always @(posedge clk) mem_rdata <= instr_at(pc);

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_valid(input string name, input logic [15:0] exp_pc,
                            input logic [15:0] exp_ir);
      chk({name, " pc"}, pc, exp_pc);
      chk({name, " ir"}, instruction, exp_ir);
      chk({name, " valid"}, {15'd0, instr_valid}, 16'd1);
      chk({name, " busy"}, {15'd0, fetch_busy}, 16'd0);
   endtask

   task automatic goto(input logic [15:0] target);
      PC_enable = 1'b1;
      jump_en   = 1'b1;
      jump_addr = target;
      step();
      PC_enable = 1'b0;
      jump_en   = 1'b0;
      step();
      step();
   endtask

   typedef struct {
      logic [15:0] start;
      logic        jmp;
      logic        br;
      logic [7:0]  disp;
      logic [15:0] jaddr;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [15:0] prev_ir;
      logic [15:0] p;

      vecs = '{
         '{16'h0010, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0011},
         '{16'h0020, 1'b0, 1'b1, 8'hFC, 16'h0000, 16'h001C},
         '{16'h0020, 1'b0, 1'b1, 8'h05, 16'h0000, 16'h0025},
         '{16'h0020, 1'b1, 1'b1, 8'h05, 16'h0400, 16'h0400},
         '{16'hFFFF, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000},
         '{16'h0002, 1'b0, 1'b1, 8'hFC, 16'h0000, 16'hFFFE},
         '{16'h0030, 1'b0, 1'b1, 8'h80, 16'h0000, 16'hFFB0},
         '{16'h1234, 1'b1, 1'b0, 8'h00, 16'hBEEF, 16'hBEEF},
         '{16'h0040, 1'b0, 1'b1, 8'h7F, 16'h0000, 16'h00BF}
      };

      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      PC_enable   = 1'b0;
      branch_en   = 1'b0;
      branch_disp = 8'h00;
      jump_en     = 1'b0;
      jump_addr   = 16'h0000;

      repeat (2) @(posedge clk);
      #1;
      chk("reset pc", pc, 16'h0000);
      chk("reset ir", instruction, 16'h0000);
      chk("reset valid", {15'd0, instr_valid}, 16'd0);
      chk("reset busy", {15'd0, fetch_busy}, 16'd1);

      rst = 1'b0;
      step();
      chk("first fetch edge1 valid", {15'd0, instr_valid}, 16'd0);
      chk("first fetch edge1 busy", {15'd0, fetch_busy}, 16'd1);
      step();
      chk_valid("first fetch", 16'h0000, 16'h0123);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_valid("idle hold", 16'h0000, 16'h0123);
      end

      // Enables without PC_enable do nothing.
      jump_en     = 1'b1;
      branch_en   = 1'b1;
      jump_addr   = 16'h7777;
      branch_disp = 8'h10;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_valid("no PC_enable", 16'h0000, 16'h0123);
      end
      jump_en   = 1'b0;
      branch_en = 1'b0;

      for (int i = 0; i < 9; i++) begin
         goto(vecs[i].start);
         chk_valid($sformatf("vec%0d start", i), vecs[i].start, instr_at(vecs[i].start));
         prev_ir     = instruction;
         PC_enable   = 1'b1;
         jump_en     = vecs[i].jmp;
         branch_en   = vecs[i].br;
         branch_disp = vecs[i].disp;
         jump_addr   = vecs[i].jaddr;
         step();
         PC_enable = 1'b0;
         jump_en   = 1'b0;
         branch_en = 1'b0;
         chk($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d fetch valid", i), {15'd0, instr_valid}, 16'd0);
         chk($sformatf("vec%0d fetch busy", i), {15'd0, fetch_busy}, 16'd1);
         chk($sformatf("vec%0d fetch ir held", i), instruction, prev_ir);
         step();
         chk($sformatf("vec%0d wait ir held", i), instruction, prev_ir);
         chk($sformatf("vec%0d wait valid", i), {15'd0, instr_valid}, 16'd0);
         step();
         chk_valid($sformatf("vec%0d done", i), vecs[i].exp_pc, instr_at(vecs[i].exp_pc));
      end

      // PC_enable held high: one advance per VALID visit.
      goto(16'h0100);
      p = 16'h0100;
      PC_enable = 1'b1;
      for (int v = 0; v < 2; v++) begin
         step();
         p = p + 16'd1;
         chk("held fetch pc", pc, p);
         chk("held fetch valid", {15'd0, instr_valid}, 16'd0);
         step();
         chk("held wait pc", pc, p);
         step();
         chk_valid("held valid", p, instr_at(p));
      end
      PC_enable = 1'b0;

      // Asynchronous reset mid-WAIT.
      goto(16'h0200);
      PC_enable = 1'b1;
      step();
      PC_enable = 1'b0;
      step();
      chk("pre-reset wait pc", pc, 16'h0201);
      #3;
      rst = 1'b1;
      #1;
      chk("async rst pc", pc, 16'h0000);
      chk("async rst ir", instruction, 16'h0000);
      chk("async rst valid", {15'd0, instr_valid}, 16'd0);
      chk("async rst busy", {15'd0, fetch_busy}, 16'd1);
      PC_enable = 1'b1;
      jump_en   = 1'b1;
      jump_addr = 16'h3333;
      repeat (3) step();
      chk("rst ignores enables pc", pc, 16'h0000);
      chk("rst held valid", {15'd0, instr_valid}, 16'd0);
      PC_enable = 1'b0;
      jump_en   = 1'b0;
      rst       = 1'b0;
      step();
      chk("post-rst edge1 valid", {15'd0, instr_valid}, 16'd0);
      step();
      chk_valid("post-rst fetch", 16'h0000, 16'h0123);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
